spw_link_fsm: RTL and testbench
===============================

// Module: spw_link_fsm
// PURPOSE
//  Sequences the SpaceWire link per ECSS-E-ST-50-12C 8.5: ErrorReset, ErrorWait, Ready, Started, Connecting, Run.
//  Consumes token-detector events (NULL/FCT/N-Char/Time-Code/error), the disconnect flag and the credit error.
//  Drives receiver reset/enable and transmitter mode; sits between the receive token detector, the TX encoder and host config.
// PARAMETERS
//  CNT_6U4   640   clock_sys cycles in 6.4 us (100 MHz default)
//  CNT_12U8  1280  clock_sys cycles in 12.8 us
//  CNT_W     11    timer width; must hold CNT_12U8-1
// PORTS
//  clock_sys         in   1  system clock
//  resetn            in   1  async active-low reset
//  link_start        in   1  host: start link (level)
//  link_disable      in   1  host: disable link (level, dominates start)
//  auto_start        in   1  host: start on first received NULL
//  rx_got_null       in   1  1-cycle pulse, NULL received (sync to clock_sys)
//  rx_got_fct        in   1  1-cycle pulse, FCT received
//  rx_got_nchar      in   1  1-cycle pulse, N-Char received
//  rx_got_time_code  in   1  1-cycle pulse, Time-Code received
//  rx_error          in   1  parity/escape error pulse
//  rx_disconnect     in   1  disconnect timeout pulse
//  credit_error      in   1  TX credit overflow pulse
//  rx_resetn_out     out  1  active-low reset to receiver
//  enable_tx         out  1  TX encoder enable
//  send_null_tx      out  1  TX restricted to NULLs
//  send_fct_tx       out  1  TX may send FCTs (N-Chars/Time-Codes blocked)
//  link_up           out  1  state==Run
//  fsm_state         out  3  current state code
//  err_count         out  8  disconnect/error event counter (see CONFIGURATION)
// BEHAVIOUR
//  Codes: ErrorReset=0 ErrorWait=1 Ready=2 Started=3 Connecting=4 Run=5; 6,7 illegal -> ErrorReset next cycle.
//  Reset: state=ErrorReset, timer=0, got_null_seen=0; rx_resetn_out=0, enable_tx=0, send_null_tx=0, send_fct_tx=0,
//   link_up=0, fsm_state=0, err_count=0. All outputs registered, decoded from next state (valid the cycle state is entered).
//  Timer: CNT_W-bit, cleared on every state change, +1 per cycle otherwise, saturates; "T(n)" = timer==n-1.
//  got_null_seen: set on rx_got_null while rx_resetn_out=1; cleared in ErrorReset.
//  err = rx_disconnect | (rx_error & got_null_seen). ctl_err = err | rx_got_fct | rx_got_nchar | rx_got_time_code.
//  enabled = !link_disable & (link_start | (auto_start & got_null_seen)).
//  ErrorReset: rx_resetn_out=0, TX off. T(CNT_6U4) -> ErrorWait.
//  ErrorWait: RX on, TX off. ctl_err -> ErrorReset; else T(CNT_12U8) -> Ready.
//  Ready: RX on, TX off. ctl_err -> ErrorReset; else enabled -> Started.
//  Started: enable_tx=1, send_null_tx=1. ctl_err or T(CNT_12U8) -> ErrorReset; else rx_got_null -> Connecting.
//  Connecting: enable_tx=1, send_fct_tx=1. (err|nchar|time_code) or T(CNT_12U8) -> ErrorReset; else rx_got_fct -> Run.
//  Run: enable_tx=1, send_null_tx=0, send_fct_tx=1, link_up=1. err | credit_error | link_disable -> ErrorReset.
//  Priority in any state: error/timeout exit beats progress exit in the same cycle.
//  rx_got_null in Started coinciding with T(CNT_12U8): timeout wins -> ErrorReset.
//  Pulses while rx_resetn_out=0 ignored. Async reset mid-operation returns to ErrorReset immediately, timer cleared.
// CONFIGURATION
//  SPW_FSM_ERR_CNT_EN defined: err_count +1 (saturating at 255) on each transition into ErrorReset from any state
//   other than ErrorReset; cleared only by resetn.
//  Undefined: err_count tied to 8'd0, no counter flops.
// TESTING
//  T1 Reset release, no stimulus: ErrorReset 640 cycles, ErrorWait 1280 cycles, then state=2, rx_resetn_out=1 at cycle 640.
//  T2 Ready, link_start=1, NULL after 100 cycles, FCT after 50 -> states 3,4,5; link_up=1; send_fct_tx=1 in 4 and 5.
//  T3 Started, no NULL for 1280 cycles -> ErrorReset exactly at T(1280); err_count=1 with SPW_FSM_ERR_CNT_EN.
//  T4 auto_start=1, link_start=0: NULL received in Ready -> Started; link_disable=1 same cycle -> stays Ready.
//  T5 Run, rx_disconnect pulse -> ErrorReset next cycle, enable_tx=0, link_up=0; same with credit_error.
//  T6 ErrorWait, rx_error before any NULL -> ignored; rx_got_fct pulse -> ErrorReset; resetn low mid-Run -> all outputs reset.

Source files
------------

// File: rtl/spw_link_fsm.sv
// spw_link_fsm: SpaceWire link initialisation state machine
// (ErrorReset, ErrorWait, Ready, Started, Connecting, Run).
//
// Ports:
//   clock_sys, resetn     system clock, async active-low reset
//   link_start            host level: start link
//   link_disable          host level: disable link, dominates start
//   auto_start            host level: start on first received NULL
//   rx_got_null/fct/nchar/time_code
//                         1-cycle receive token pulses
//   rx_error              parity/escape error pulse
//   rx_disconnect         disconnect timeout pulse
//   credit_error          TX credit overflow pulse
//   rx_resetn_out         active-low receiver reset
//   enable_tx             TX encoder enable
//   send_null_tx          TX restricted to NULLs
//   send_fct_tx           TX may send FCTs
//   link_up               high in Run
//   fsm_state             current state code (0..5)
//   err_count             entries into ErrorReset, saturating at 255
//
// Optional feature: define SPW_FSM_ERR_CNT_EN to build the error-event
// counter. Without it err_count is tied to zero and has no flops.
//
// All outputs are registered and decoded from the next state, so they
// are valid in the first cycle a state is occupied.

module spw_link_fsm #(
    parameter int unsigned CNT_6U4  = 640,
    parameter int unsigned CNT_12U8 = 1280,
    parameter int unsigned CNT_W    = 11
) (
    input  logic       clock_sys,
    input  logic       resetn,
    input  logic       link_start,
    input  logic       link_disable,
    input  logic       auto_start,
    input  logic       rx_got_null,
    input  logic       rx_got_fct,
    input  logic       rx_got_nchar,
    input  logic       rx_got_time_code,
    input  logic       rx_error,
    input  logic       rx_disconnect,
    input  logic       credit_error,
    output logic       rx_resetn_out,
    output logic       enable_tx,
    output logic       send_null_tx,
    output logic       send_fct_tx,
    output logic       link_up,
    output logic [2:0] fsm_state,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        ErrorReset = 3'd0,
        ErrorWait  = 3'd1,
        Ready      = 3'd2,
        Started    = 3'd3,
        Connecting = 3'd4,
        Run        = 3'd5
    } state_t;

    // Timer value on the last cycle of each interval.
    localparam logic [CNT_W-1:0] LAST_6U4  = CNT_W'(CNT_6U4 - 1);
    localparam logic [CNT_W-1:0] LAST_12U8 = CNT_W'(CNT_12U8 - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             got_null_seen;

    logic err, ctl_err, enabled, t_6u4, t_12u8;

    // rx_error only counts once the link has proven it can see NULLs.
    assign err     = rx_disconnect | (rx_error & got_null_seen);
    assign ctl_err = err | rx_got_fct | rx_got_nchar | rx_got_time_code;
    assign enabled = ~link_disable & (link_start | (auto_start & got_null_seen));
    assign t_6u4   = (timer_q == LAST_6U4);
    assign t_12u8  = (timer_q == LAST_12U8);

    // Error/timeout exits are tested before progress exits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ErrorReset: if (t_6u4) state_d = ErrorWait;
            ErrorWait: begin
                if (ctl_err)     state_d = ErrorReset;
                else if (t_12u8) state_d = Ready;
            end
            Ready: begin
                if (ctl_err)      state_d = ErrorReset;
                else if (enabled) state_d = Started;
            end
            Started: begin
                if (ctl_err | t_12u8) state_d = ErrorReset;
                else if (rx_got_null) state_d = Connecting;
            end
            Connecting: begin
                if (err | rx_got_nchar | rx_got_time_code | t_12u8) state_d = ErrorReset;
                else if (rx_got_fct)                                 state_d = Run;
            end
            Run: if (err | credit_error | link_disable) state_d = ErrorReset;
            default: state_d = ErrorReset;
        endcase
    end

    always_comb begin
        if (state_d != state_q)     timer_d = '0;
        else if (timer_q != '1)     timer_d = timer_q + 1'b1;
        else                        timer_d = timer_q;
    end

    always_ff @(posedge clock_sys or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ErrorReset;
            timer_q       <= '0;
            got_null_seen <= 1'b0;
            rx_resetn_out <= 1'b0;
            enable_tx     <= 1'b0;
            send_null_tx  <= 1'b0;
            send_fct_tx   <= 1'b0;
            link_up       <= 1'b0;
            fsm_state     <= 3'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            // Receiver is held in reset in ErrorReset, so NULLs only count outside it.
            if (state_q == ErrorReset)           got_null_seen <= 1'b0;
            else if (rx_got_null && rx_resetn_out) got_null_seen <= 1'b1;
            rx_resetn_out <= (state_d != ErrorReset);
            enable_tx     <= (state_d inside {Started, Connecting, Run});
            send_null_tx  <= (state_d == Started);
            send_fct_tx   <= (state_d inside {Connecting, Run});
            link_up       <= (state_d == Run);
            fsm_state     <= state_d;
        end
    end

`ifdef SPW_FSM_ERR_CNT_EN
    always_ff @(posedge clock_sys or negedge resetn) begin
        if (!resetn) begin
            err_count <= 8'd0;
        end else if (state_d == ErrorReset && state_q != ErrorReset && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_spw_link_fsm.sv
// Directed bench for spw_link_fsm with default 640/1280-cycle timers.
module tb_spw_link_fsm;

    logic       clock_sys = 1'b0;
    logic       resetn;
    logic       link_start, link_disable, auto_start;
    logic       rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time_code;
    logic       rx_error, rx_disconnect, credit_error;
    logic       rx_resetn_out, enable_tx, send_null_tx, send_fct_tx, link_up;
    logic [2:0] fsm_state;
    logic [7:0] err_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_err  = 0;

    always #5 clock_sys = ~clock_sys;

    spw_link_fsm dut (
        .clock_sys        (clock_sys),
        .resetn           (resetn),
        .link_start       (link_start),
        .link_disable     (link_disable),
        .auto_start       (auto_start),
        .rx_got_null      (rx_got_null),
        .rx_got_fct       (rx_got_fct),
        .rx_got_nchar     (rx_got_nchar),
        .rx_got_time_code (rx_got_time_code),
        .rx_error         (rx_error),
        .rx_disconnect    (rx_disconnect),
        .credit_error     (credit_error),
        .rx_resetn_out    (rx_resetn_out),
        .enable_tx        (enable_tx),
        .send_null_tx     (send_null_tx),
        .send_fct_tx      (send_fct_tx),
        .link_up          (link_up),
        .fsm_state        (fsm_state),
        .err_count        (err_count)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned exp_cnt();
`ifdef SPW_FSM_ERR_CNT_EN
        return exp_err;
`else
        return 0;
`endif
    endfunction

    // Advance n rising edges; sample/drive 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock_sys);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        link_start = 0; link_disable = 0; auto_start = 0;
        rx_got_null = 0; rx_got_fct = 0; rx_got_nchar = 0; rx_got_time_code = 0;
        rx_error = 0; rx_disconnect = 0; credit_error = 0;
        exp_err = 0;
        #23;
        @(negedge clock_sys);
        resetn = 1'b1;
    endtask

    task automatic to_ready();
        do_reset();
        tick(640 + 1280);
    endtask

    // From Ready: start, NULL, FCT -> Run.
    task automatic ready_to_run();
        link_start = 1; tick(1);
        rx_got_null = 1; tick(1); rx_got_null = 0;
        rx_got_fct = 1; tick(1); rx_got_fct = 0;
    endtask

    initial begin
        // T1: reset values and the two init timers.
        do_reset();
        check_eq("t1_state_at_start", fsm_state, 0);
        check_eq("t1_rxrst_at_start", rx_resetn_out, 0);
        check_eq("t1_entx_at_start", enable_tx, 0);
        check_eq("t1_errcnt_at_start", err_count, 0);
        tick(639);
        check_eq("t1_state_639", fsm_state, 0);
        check_eq("t1_rxrst_639", rx_resetn_out, 0);
        tick(1);
        check_eq("t1_state_640", fsm_state, 1);
        check_eq("t1_rxrst_640", rx_resetn_out, 1);
        tick(1279);
        check_eq("t1_state_ew_end", fsm_state, 1);
        tick(1);
        check_eq("t1_state_ready", fsm_state, 2);
        check_eq("t1_entx_ready", enable_tx, 0);
        tick(20);
        check_eq("t1_ready_idle", fsm_state, 2);

        // T2: normal bring-up to Run.
        link_start = 1; tick(1);
        check_eq("t2_started", fsm_state, 3);
        check_eq("t2_started_entx", enable_tx, 1);
        check_eq("t2_started_null", send_null_tx, 1);
        check_eq("t2_started_fct", send_fct_tx, 0);
        tick(99);
        check_eq("t2_started_wait", fsm_state, 3);
        rx_got_null = 1; tick(1); rx_got_null = 0;
        check_eq("t2_connecting", fsm_state, 4);
        check_eq("t2_conn_fct", send_fct_tx, 1);
        check_eq("t2_conn_null", send_null_tx, 0);
        tick(49);
        check_eq("t2_conn_wait", fsm_state, 4);
        rx_got_fct = 1; tick(1); rx_got_fct = 0;
        check_eq("t2_run", fsm_state, 5);
        check_eq("t2_run_linkup", link_up, 1);
        check_eq("t2_run_fct", send_fct_tx, 1);
        check_eq("t2_run_null", send_null_tx, 0);

        // T5a: disconnect in Run.
        rx_disconnect = 1; tick(1); rx_disconnect = 0; exp_err++;
        check_eq("t5_disc_state", fsm_state, 0);
        check_eq("t5_disc_entx", enable_tx, 0);
        check_eq("t5_disc_linkup", link_up, 0);
        check_eq("t5_disc_rxrst", rx_resetn_out, 0);
        check_eq("t5_disc_errcnt", err_count, exp_cnt());

        // T5b: credit error in Run.
        to_ready();
        ready_to_run();
        check_eq("t5_run2", fsm_state, 5);
        credit_error = 1; tick(1); credit_error = 0; exp_err++;
        check_eq("t5_credit_state", fsm_state, 0);
        check_eq("t5_credit_linkup", link_up, 0);
        check_eq("t5_credit_errcnt", err_count, exp_cnt());

        // T5c: link_disable in Run.
        to_ready();
        ready_to_run();
        link_disable = 1; tick(1); exp_err++;
        check_eq("t5_disable_state", fsm_state, 0);
        link_disable = 0;

        // T3: Started timeout at exactly 1280 cycles.
        to_ready();
        link_start = 1; tick(1);
        tick(1279);
        check_eq("t3_started_1279", fsm_state, 3);
        tick(1); exp_err++;
        check_eq("t3_timeout_state", fsm_state, 0);
        check_eq("t3_timeout_errcnt", err_count, exp_cnt());

        // T3b: NULL coinciding with the Started timeout loses.
        to_ready();
        link_start = 1; tick(1);
        tick(1279);
        rx_got_null = 1; tick(1); rx_got_null = 0; exp_err++;
        check_eq("t3_null_vs_timeout", fsm_state, 0);

        // T4: auto_start with link_disable, then released.
        to_ready();
        auto_start = 1; link_disable = 1;
        rx_got_null = 1; tick(1); rx_got_null = 0;
        tick(3);
        check_eq("t4_disabled_ready", fsm_state, 2);
        link_disable = 0; tick(1);
        check_eq("t4_release_started", fsm_state, 3);

        // T4b: auto_start, NULL in Ready -> Started.
        to_ready();
        auto_start = 1;
        rx_got_null = 1; tick(1); rx_got_null = 0;
        tick(1);
        check_eq("t4_auto_started", fsm_state, 3);

        // Connecting: N-Char is an error.
        to_ready();
        link_start = 1; tick(1);
        rx_got_null = 1; tick(1); rx_got_null = 0;
        rx_got_nchar = 1; tick(1); rx_got_nchar = 0;
        check_eq("conn_nchar_state", fsm_state, 0);

        // T6: ErrorWait ignores rx_error before NULL, exits on FCT.
        do_reset();
        tick(650);
        rx_error = 1; tick(1); rx_error = 0;
        check_eq("t6_rxerr_ignored", fsm_state, 1);
        rx_got_fct = 1; tick(1); rx_got_fct = 0; exp_err = 1;
        check_eq("t6_fct_state", fsm_state, 0);
        check_eq("t6_fct_errcnt", err_count, exp_cnt());

        // T6b: async reset mid-Run.
        to_ready();
        ready_to_run();
        check_eq("t6_run", link_up, 1);
        @(negedge clock_sys);
        #2 resetn = 1'b0;
        #1;
        check_eq("t6_areset_state", fsm_state, 0);
        check_eq("t6_areset_rxrst", rx_resetn_out, 0);
        check_eq("t6_areset_entx", enable_tx, 0);
        check_eq("t6_areset_fct", send_fct_tx, 0);
        check_eq("t6_areset_linkup", link_up, 0);
        check_eq("t6_areset_errcnt", err_count, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
